// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, ALU select codes, FSM states.
// Optional multiply support is built when ALU_SEQ_MUL_EN is defined.
package alu_seq_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SHLN = 4'b0011;
    localparam logic [3:0] OP_SHRN = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SUB  = 3'b001;
    localparam logic [2:0] SEL_SHR1 = 3'b010;
    localparam logic [2:0] SEL_SHL1 = 3'b011;
    localparam logic [2:0] SEL_AND  = 3'b101;
    localparam logic [2:0] SEL_OR   = 3'b110;
    localparam logic [2:0] SEL_XOR  = 3'b111;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StExec     = 3'd1,
`ifdef ALU_SEQ_MUL_EN
        StMulAdd   = 3'd2,
        StMulShift = 3'd3,
`endif
        StShift    = 3'd4,
        StDone     = 3'd5
    } state_e;

    // Ops that complete in a single ALU pass.
    function automatic logic is_single_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command and response handshake bundle for the ALU sequencer.
interface alu_seq_ctrl_if;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [3:0]  Cmd_Op;
    logic [31:0] Cmd_A;
    logic [31:0] Cmd_B;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [31:0] Rsp_Data;
    logic        Rsp_Carry;
    logic        Rsp_Err;
    logic        Busy;

    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Rsp_Ready,
        output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Carry, Rsp_Err, Busy
    );

    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Rsp_Ready,
        input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_Carry, Rsp_Err, Busy
    );
endinterface

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational 32-bit ALU: add, sub, shift-by-1 left/right, and, or, xor.
module alu_seq_ctrl_alu
    import alu_seq_ctrl_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_sel,
    output logic [31:0] o_result,
    output logic        o_carry
);

    // Decode select into result and carry-out.
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_sel)
            SEL_ADD:  {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
            SEL_SUB:  {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
            SEL_SHL1: {o_carry, o_result} = {i_a, 1'b0};
            SEL_SHR1: {o_result, o_carry} = {1'b0, i_a};
            SEL_AND:  o_result = i_a & i_b;
            SEL_OR:   o_result = i_a | i_b;
            SEL_XOR:  o_result = i_a ^ i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around the ALU. Single ops take one pass; SHLN/SHRN iterate one-bit
// shifts; MUL (built only with ALU_SEQ_MUL_EN) iterates shift-add. One registered response
// per command.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave io
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_e             r_state;
    logic [31:0]        r_acc;
    logic [31:0]        r_m;
`ifdef ALU_SEQ_MUL_EN
    logic [31:0]        r_q;
`endif
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_op;
    logic               r_carry;
    logic               r_err;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic               r_busy;

    logic [31:0]        w_alu_a;
    logic [2:0]         w_alu_sel;
    logic [31:0]        w_alu_res;
    logic               w_alu_co;

    // Route operands and select into the shared ALU based on the current step.
    always_comb begin
        w_alu_a   = r_acc;
        w_alu_sel = SEL_ADD;
        case (r_state)
            StExec: begin
                case (r_op)
                    OP_SUB:  w_alu_sel = SEL_SUB;
                    OP_AND:  w_alu_sel = SEL_AND;
                    OP_OR:   w_alu_sel = SEL_OR;
                    OP_XOR:  w_alu_sel = SEL_XOR;
                    default: w_alu_sel = SEL_ADD;
                endcase
            end
            StShift: w_alu_sel = (r_op == OP_SHLN) ? SEL_SHL1 : SEL_SHR1;
`ifdef ALU_SEQ_MUL_EN
            StMulAdd: w_alu_sel = SEL_ADD;
            StMulShift: begin
                w_alu_a   = r_m;
                w_alu_sel = SEL_SHL1;
            end
`endif
            default: w_alu_sel = SEL_ADD;
        endcase
    end

    alu_seq_ctrl_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (r_m),
        .i_sel    (w_alu_sel),
        .o_result (w_alu_res),
        .o_carry  (w_alu_co)
    );

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_m         <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_q         <= '0;
`endif
            r_cnt       <= '0;
            r_op        <= '0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_cmd_ready <= 1'b1;
                    if (io.Cmd_Valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= io.Cmd_Op;
                        r_carry     <= 1'b0;
                        r_err       <= 1'b0;
                        r_acc       <= io.Cmd_A;
                        r_m         <= io.Cmd_B;
                        r_cnt       <= io.Cmd_B[SHAMT_W-1:0];
                        r_state     <= StExec;
                        case (io.Cmd_Op)
`ifdef ALU_SEQ_MUL_EN
                            OP_MUL: begin
                                r_acc <= '0;
                                r_m   <= io.Cmd_A;
                                r_q   <= io.Cmd_B;
                                // B=0 spends one idle EXEC cycle and returns 0.
                                if (io.Cmd_B == '0) begin
                                    r_state <= StExec;
                                end else if (io.Cmd_B[0]) begin
                                    r_state <= StMulAdd;
                                end else begin
                                    r_state <= StMulShift;
                                end
                            end
`endif
                            OP_SHLN, OP_SHRN: r_state <= StShift;
                            default: r_state <= StExec;
                        endcase
                    end
                end
                StExec: begin
                    if (is_single_op(r_op)) begin
                        r_acc   <= w_alu_res;
                        r_carry <= (r_op == OP_ADD) && w_alu_co;
                    end else begin
                        r_acc   <= '0;
                        r_carry <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        r_err   <= (r_op != OP_MUL);
`else
                        r_err   <= 1'b1;
`endif
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StShift: begin
                    // A zero count still spends one cycle, leaving A unchanged.
                    if (r_cnt != '0) begin
                        r_acc <= w_alu_res;
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                    if (r_cnt <= CNT_ONE) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                StMulAdd: begin
                    r_acc   <= w_alu_res;
                    r_carry <= r_carry | w_alu_co;
                    r_state <= StMulShift;
                end
                StMulShift: begin
                    r_m <= w_alu_res;
                    r_q <= r_q >> 1;
                    if (r_q[31:1] == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StDone;
                    end else if (r_q[1]) begin
                        r_state <= StMulAdd;
                    end else begin
                        r_state <= StMulShift;
                    end
                end
`endif
                StDone: begin
                    if (io.Rsp_Ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io.Cmd_Ready = r_cmd_ready;
    assign io.Rsp_Valid = r_rsp_valid;
    assign io.Rsp_Data  = r_acc;
    assign io.Rsp_Carry = r_carry;
    assign io.Rsp_Err   = r_err;
    assign io.Busy      = r_busy;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl; MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    alu_seq_ctrl_if u_if ();

    alu_seq_ctrl #(
        .SHAMT_W (5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one command, measure latency, optionally stall the response, then retire it.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_data,
                           input logic exp_carry, input logic exp_err, input int exp_lat,
                           input int hold);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!u_if.Cmd_Ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!u_if.Cmd_Ready) check_eq({tag, ".wait_rdy"}, 32'(u_if.Cmd_Ready), 32'd1);
        u_if.Cmd_Valid = 1'b1;
        u_if.Cmd_Op    = op;
        u_if.Cmd_A     = a;
        u_if.Cmd_B     = b;
        @(posedge clk);
        #1 u_if.Cmd_Valid = 1'b0;
        @(negedge clk);
        lat = 1;
        check_eq({tag, ".busy"}, 32'(u_if.Busy), 32'd1);
        check_eq({tag, ".rdy_lo"}, 32'(u_if.Cmd_Ready), 32'd0);
        while (!u_if.Rsp_Valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".data"}, u_if.Rsp_Data, exp_data);
        check_eq({tag, ".carry"}, 32'(u_if.Rsp_Carry), 32'(exp_carry));
        check_eq({tag, ".err"}, 32'(u_if.Rsp_Err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, ".hold_data"}, u_if.Rsp_Data, exp_data);
            check_eq({tag, ".hold_vld"}, 32'(u_if.Rsp_Valid), 32'd1);
            check_eq({tag, ".hold_rdy"}, 32'(u_if.Cmd_Ready), 32'd0);
        end
        u_if.Rsp_Ready = 1'b1;
        @(posedge clk);
        #1 u_if.Rsp_Ready = 1'b0;
        @(negedge clk);
        check_eq({tag, ".rdy_after"}, 32'(u_if.Cmd_Ready), 32'd1);
        check_eq({tag, ".vld_after"}, 32'(u_if.Rsp_Valid), 32'd0);
        check_eq({tag, ".busy_after"}, 32'(u_if.Busy), 32'd0);
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        rst            = 1'b1;
        u_if.Cmd_Valid = 1'b0;
        u_if.Cmd_Op    = '0;
        u_if.Cmd_A     = '0;
        u_if.Cmd_B     = '0;
        u_if.Rsp_Ready = 1'b0;

        // Reset state and registered Cmd_Ready release.
        @(negedge clk);
        check_eq("rst.vld", 32'(u_if.Rsp_Valid), 32'd0);
        check_eq("rst.busy", 32'(u_if.Busy), 32'd0);
        check_eq("rst.rdy", 32'(u_if.Cmd_Ready), 32'd0);
        check_eq("rst.data", u_if.Rsp_Data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rel.rdy0", 32'(u_if.Cmd_Ready), 32'd0);
        @(negedge clk);
        check_eq("rel.rdy1", 32'(u_if.Cmd_Ready), 32'd1);

        run_cmd("add_ovf", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 2, 0);
        run_cmd("add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 2, 0);
        run_cmd("sub_neg", 4'b0001, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 1'b0, 2, 0);
        run_cmd("and", 4'b0101, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 2, 0);
        run_cmd("or", 4'b0110, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 2, 0);
        run_cmd("xor_hold", 4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0,
                2, 5);
        run_cmd("shrn31", 4'b0100, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 32, 0);
        run_cmd("shln0", 4'b0011, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 2, 0);
        run_cmd("shln4", 4'b0011, 32'd3, 32'd4, 32'h0000_0030, 1'b0, 1'b0, 5, 0);
        // Only the low five bits of B count: 0x21 shifts by 1.
        run_cmd("shln_msk", 4'b0011, 32'd1, 32'h0000_0021, 32'd2, 1'b0, 1'b0, 2, 0);
        run_cmd("bad_op", 4'b1010, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 2, 0);
`ifdef ALU_SEQ_MUL_EN
        run_cmd("mul", 4'b0010, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 21, 0);
        run_cmd("mul_b0", 4'b0010, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 2, 0);
        run_cmd("mul_cy", 4'b0010, 32'hC000_0000, 32'd3, 32'h4000_0000, 1'b1, 1'b0, 5, 0);
`else
        run_cmd("mul_off", 4'b0010, 32'd1234, 32'd5678, 32'd0, 1'b0, 1'b1, 2, 0);
`endif

        // Asynchronous reset in the middle of a long command.
        @(negedge clk);
        u_if.Cmd_Valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        u_if.Cmd_Op    = 4'b0010;
        u_if.Cmd_A     = 32'd1234;
        u_if.Cmd_B     = 32'd5678;
`else
        u_if.Cmd_Op    = 4'b0100;
        u_if.Cmd_A     = 32'h8000_0000;
        u_if.Cmd_B     = 32'd31;
`endif
        @(posedge clk);
        #1 u_if.Cmd_Valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("mid.vld", 32'(u_if.Rsp_Valid), 32'd0);
        check_eq("mid.busy", 32'(u_if.Busy), 32'd0);
        check_eq("mid.rdy", 32'(u_if.Cmd_Ready), 32'd0);
        check_eq("mid.data", u_if.Rsp_Data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid.rel0", 32'(u_if.Cmd_Ready), 32'd0);
        @(negedge clk);
        check_eq("mid.rel1", 32'(u_if.Cmd_Ready), 32'd1);
        run_cmd("sub_post", 4'b0001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
